// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, the digit-to-segment table and the
// conversion FSM state type used by score_display_mux.
package seg7_pkg;

  // Active-low segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Any code outside 0..9 renders as a dash so corrupt BCD is visible
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    if (d <= 4'd9) return SEG_TABLE[d];
    return SEG_DASH;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift/add-3 (double dabble) binary to BCD converter.
// A start pulse captures bin; SCORE_W steps follow, one per clock.
// done is high during the final step, so bcd/ovf are settled from the
// following cycle until the next start. ovf is a sticky flag raised when
// a set bit is shifted out above the NDIG digits, i.e. bin > 10^NDIG-1.
module bin2bcd_seq #(
  parameter int SCORE_W = 7,
  parameter int NDIG    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SCORE_W-1:0]  bin,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd,
  output logic                ovf
);

  localparam int BCD_W = 4 * NDIG;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] r_sh;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [BCD_W-1:0]   w_adj;

  // Add 3 to every digit that is 5 or more before the next doubling
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < NDIG; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  // Capture on start, then shift one binary bit into the BCD register per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (start) begin
      r_sh  <= bin;
      r_bcd <= '0;
      r_cnt <= CNT_W'(SCORE_W);
      r_ovf <= 1'b0;
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_sh[SCORE_W-1]};
      r_sh  <= r_sh << 1;
      r_ovf <= r_ovf | w_adj[BCD_W-1];
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign done = (r_cnt == CNT_W'(1));
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule

// File: rtl/score_display_mux.sv
// Two-score multiplexed 7-segment driver. Low half of the digits shows
// right_score, high half shows left_score. Scores are converted to BCD
// sequentially and committed to the display registers in one cycle, so
// a digit never shows a half-updated score.
// Optional feature macro: SCORE_DISPLAY_BLINK_EN adds the blink port and a
// free-running blink counter that masks the anodes of a selected half.
//
// Handshake: load is a single-cycle request. In IDLE it captures both scores
// immediately. While busy (CONV or COMMIT) a load only sets one pending flag;
// any number of such loads collapse into a single re-capture of the live
// inputs at COMMIT. busy stays high from the capture until the last commit.
module score_display_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCORE_W     = 7,
  parameter int REFRESH_DIV = 2048,
  parameter int BLINK_LOG2  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SCORE_W-1:0]    left_score,
  input  logic [SCORE_W-1:0]    right_score,
  input  logic                  load,
  input  logic                  blank_leading,
  output logic                  busy,
  output logic [6:0]            seg,
`ifdef SCORE_DISPLAY_BLINK_EN
  input  logic [1:0]            blink,
`endif
  output logic [NUM_DIGITS-1:0] AN
);

  localparam int HALF  = NUM_DIGITS / 2;
  localparam int BCD_W = 4 * HALF;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(REFRESH_DIV);

  if (((NUM_DIGITS % 2) != 0) || (NUM_DIGITS < 2) || (NUM_DIGITS > 8) ||
      (SCORE_W < 1) || (SCORE_W > 16) || (REFRESH_DIV < 2) || (BLINK_LOG2 < 1)) begin : g_bad_params
    $error("score_display_mux: illegal parameter set");
  end

  // Scan state
  logic [DIV_W-1:0]      r_div;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  w_tc;

  // Conversion state
  conv_state_t           r_state;
  conv_state_t           w_next_state;
  logic                  r_pend;
  logic                  w_start;
  logic                  w_commit;

  // Converter results and committed display contents
  logic [BCD_W-1:0]      w_bcd_l, w_bcd_r;
  logic                  w_ovf_l, w_ovf_r;
  logic                  w_done_l, w_done_r;
  logic [BCD_W-1:0]      r_disp_l, r_disp_r;
  logic                  r_ovf_l, r_ovf_r;

  // Digit decode for the index about to be enabled
  logic                  w_is_left;
  logic [IDX_W-1:0]      w_pos;
  logic [BCD_W-1:0]      w_half_bcd;
  logic                  w_half_ovf;
  logic [3:0]            w_nib;
  logic                  w_upper_zero;
  logic [6:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_an_next;

  assign w_tc = (r_div == DIV_W'(REFRESH_DIV - 1));

  // Refresh divider and scan index; AN/seg load together with the index step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else if (w_tc) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Pick the digit for r_idx, applying saturation dash and leading-zero blanking
  always_comb begin
    w_is_left    = (r_idx >= IDX_W'(HALF));
    w_pos        = w_is_left ? (r_idx - IDX_W'(HALF)) : r_idx;
    w_half_bcd   = w_is_left ? r_disp_l : r_disp_r;
    w_half_ovf   = w_is_left ? r_ovf_l : r_ovf_r;
    w_nib        = 4'h0;
    w_upper_zero = 1'b1;
    for (int k = 0; k < HALF; k++) begin
      if (k == int'(w_pos)) w_nib = w_half_bcd[4*k +: 4];
      if ((k >= int'(w_pos)) && (w_half_bcd[4*k +: 4] != 4'h0)) w_upper_zero = 1'b0;
    end
    if (w_half_ovf)
      w_seg_next = SEG_DASH;
    else if (blank_leading && (w_pos != '0) && w_upper_zero)
      w_seg_next = SEG_BLANK;
    else
      w_seg_next = bcd_to_seg(w_nib);
    w_an_next = ~(NUM_DIGITS'(1) << r_idx);
  end

  // Conversion FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Conversion FSM next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (load) w_next_state = CONV;
      CONV:    if (w_done_l && w_done_r) w_next_state = COMMIT;
      COMMIT:  w_next_state = (r_pend || load) ? CONV : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Conversion FSM outputs
  always_comb begin
    busy     = (r_state != IDLE);
    w_commit = (r_state == COMMIT);
    w_start  = ((r_state == IDLE) && load) || ((r_state == COMMIT) && (r_pend || load));
  end

  // Pending flag: loads seen mid-conversion, consumed by the next COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_pend <= 1'b0;
    else if ((r_state == CONV) && load)    r_pend <= 1'b1;
    else if (r_state == COMMIT)            r_pend <= 1'b0;
  end

  // Both halves commit in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_l <= '0;
      r_disp_r <= '0;
      r_ovf_l  <= 1'b0;
      r_ovf_r  <= 1'b0;
    end else if (w_commit) begin
      r_disp_l <= w_bcd_l;
      r_disp_r <= w_bcd_r;
      r_ovf_l  <= w_ovf_l;
      r_ovf_r  <= w_ovf_r;
    end
  end

  bin2bcd_seq #(.SCORE_W(SCORE_W), .NDIG(HALF)) u_bcd_l (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .bin   (left_score),
    .done  (w_done_l),
    .bcd   (w_bcd_l),
    .ovf   (w_ovf_l)
  );

  bin2bcd_seq #(.SCORE_W(SCORE_W), .NDIG(HALF)) u_bcd_r (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .bin   (right_score),
    .done  (w_done_r),
    .bcd   (w_bcd_r),
    .ovf   (w_ovf_r)
  );

  assign seg = r_seg;

`ifdef SCORE_DISPLAY_BLINK_EN
  logic [BLINK_LOG2-1:0] r_blink_cnt;
  logic [NUM_DIGITS-1:0] w_blink_mask;

  // Free-running blink timebase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_blink_cnt <= '0;
    else        r_blink_cnt <= r_blink_cnt + BLINK_LOG2'(1);
  end

  // Hide a whole half during the upper phase of the blink period
  always_comb begin
    w_blink_mask = {{HALF{blink[1] & r_blink_cnt[BLINK_LOG2-1]}},
                    {HALF{blink[0] & r_blink_cnt[BLINK_LOG2-1]}}};
    AN = r_an | w_blink_mask;
  end
`else
  assign AN = r_an;
`endif

endmodule
